// File: rtl/clefia_byte_loader.sv
// Byte-serial front end of the CLEFIA datapath: packs 16 tagged bytes into one
// big-endian 128-bit block and holds it for the round core under valid/ready.
module clefia_byte_loader #(
    parameter int NBYTES = 16,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_in,
    input  logic                  byte_is_key,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  clear,
    output logic [8*NBYTES-1:0]   block_out,
    output logic                  block_is_key,
    output logic                  block_valid,
    input  logic                  block_ready,
    output logic                  tag_err
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [8*NBYTES-1:0] block_q;
    logic                key_q;
    logic                tag_err_q;
    logic [CNT_W-1:0]    slot_d;

    // Byte slot counted from the LSB end, so the first byte lands on top.
    assign slot_d = LAST - count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            count_q   <= '0;
            block_q   <= '0;
            key_q     <= 1'b0;
            tag_err_q <= 1'b0;
        end else if (clear) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (byte_valid) begin
                        block_q[{slot_d, 3'b000} +: 8] <= byte_in;
                        if (count_q == '0) begin
                            key_q <= byte_is_key;
                        end else if (byte_is_key != key_q) begin
                            tag_err_q <= 1'b1;
                        end
                        if (count_q == LAST) begin
                            count_q <= '0;
                            state_q <= HOLD;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (block_ready) begin
                        state_q <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    // Handshake outputs come straight from the state register.
    assign byte_ready   = (state_q == FILL);
    assign block_valid  = (state_q == HOLD);
    assign block_out    = block_q;
    assign block_is_key = key_q;
    assign tag_err      = tag_err_q;

endmodule

// File: tb/tb_clefia_byte_loader.sv
// Self-checking bench for clefia_byte_loader: directed steps plus random traffic
// against a queue-based model of accepted bytes.
module tb_clefia_byte_loader;

    localparam int NB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     byte_in;
    logic           byte_is_key;
    logic           byte_valid;
    logic           byte_ready;
    logic           clear;
    logic [127:0]   block_out;
    logic           block_is_key;
    logic           block_valid;
    logic           block_ready;
    logic           tag_err;

    int total = 0;
    int bad   = 0;

    // model: bytes of the block in progress, last completed block, handoff state
    logic [7:0]     q_b[$];
    bit             m_hold;
    bit             m_fresh;
    logic [127:0]   m_block;
    logic           m_key;
    logic           m_err;

    always #5 clk = ~clk;

    clefia_byte_loader #(.NBYTES(16), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_is_key  (byte_is_key),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .clear        (clear),
        .block_out    (block_out),
        .block_is_key (block_is_key),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .tag_err      (tag_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic bv, input logic [7:0] b, input logic k,
                              input logic br, input logic clr);
        if (rst) begin
            q_b.delete();
            m_hold = 0; m_fresh = 1; m_block = '0; m_key = 0; m_err = 0;
        end else if (clr) begin
            q_b.delete();
            m_hold = 0;
        end else if (m_hold) begin
            if (br) m_hold = 0;
        end else if (bv) begin
            if (q_b.size() == 0) m_key = k;
            else if (k !== m_key) m_err = 1;
            q_b.push_back(b);
            m_fresh = 0;
            if (q_b.size() == NB) begin
                for (int i = 0; i < NB; i++) m_block = {m_block[119:0], q_b[i]};
                q_b.delete();
                m_hold = 1;
            end
        end
    endtask

    task automatic check_all();
        check("byte_ready", byte_ready, !m_hold);
        check("block_valid", block_valid, m_hold);
        check("block_is_key", block_is_key, m_key);
        check("tag_err", tag_err, m_err);
        if (m_hold || m_fresh) check("block_out", block_out, m_block);
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic k,
                        input logic br, input logic clr);
        byte_valid  = bv;
        byte_in     = b;
        byte_is_key = k;
        block_ready = br;
        clear       = clr;
        @(posedge clk);
        #1;
        model_edge(bv, b, k, br, clr);
        check_all();
    endtask

    initial begin
        logic [7:0] rb;
        logic       rk;
        int         n;
        rst = 1'b1;
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        check("rst_block_out", block_out, 128'h0);
        rst = 1'b0;

        // full block, back to back, core always ready
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 1, 0);
        check("full_valid", block_valid, 1'b1);
        check("full_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("full_key", block_is_key, 1'b0);
        step(0, 8'h00, 0, 1, 0);
        check("full_release_valid", block_valid, 1'b0);
        check("full_release_ready", byte_ready, 1'b1);

        // key block with back-pressure; source keeps presenting a byte
        for (int i = 0; i < 16; i++) step(1, 8'(8'hFF - i), 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'h77, 1, 0, 0);
            check("bp_block", block_out, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
            check("bp_ready", byte_ready, 1'b0);
        end
        check("bp_key", block_is_key, 1'b1);
        step(0, 8'h00, 0, 1, 0);
        check("bp_release", block_valid, 1'b0);

        // gapped input
        for (int i = 0; i < 32; i++) begin
            step(i % 2 == 0, 8'hA5, 0, 0, 0);
            if (i < 30) check("gap_not_valid", block_valid, 1'b0);
        end
        check("gap_valid", block_valid, 1'b1);
        check("gap_block", block_out, {16{8'hA5}});
        step(0, 8'h00, 0, 1, 0);

        // tag error on the 5th byte
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(8'h30 + i), (i == 4), 0, 0);
            if (i == 3) check("tag_before", tag_err, 1'b0);
            if (i == 4) check("tag_after", tag_err, 1'b1);
        end
        check("tag_key", block_is_key, 1'b0);
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 8'($urandom), 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        check("tag_sticky", tag_err, 1'b1);

        // clear mid-block drops the byte presented with it
        for (int i = 0; i < 7; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
        step(1, 8'h99, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        check("clear_block", block_out, 128'h101112131415161718191A1B1C1D1E1F);
        // clear in HOLD beats block_ready and releases the block
        step(1, 8'h55, 0, 1, 1);
        check("clear_hold", block_valid, 1'b0);

        // random traffic
        rk = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 15) == 0) rk = ~rk;
            step($urandom_range(0, 3) != 0, rb, rk, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 24) == 0);
        end

        // reset while holding a block
        n = 0;
        while (!m_hold && n < 40) begin
            step(1, 8'($urandom), 0, 0, 0);
            n++;
        end
        check("reach_hold", block_valid, 1'b1);
        rst = 1'b1;
        step(1, 8'h42, 1, 0, 1);
        rst = 1'b0;
        check("rst_hold_valid", block_valid, 1'b0);
        check("rst_hold_block", block_out, 128'h0);
        check("rst_hold_err", tag_err, 1'b0);
        check("rst_hold_ready", byte_ready, 1'b1);
        step(0, 8'h00, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clefia_byte_loader.md
Name: clefia_byte_loader

Overview:
- Byte-serial front end of the CLEFIA datapath. Sits directly downstream of the 8-bit key/data input multiplexer.
- Consumes the selected byte stream together with the multiplexer select, which acts as the key/data tag.
- Assembles 16 bytes into one 128-bit block, big-endian (first byte lands in [127:120]).
- Presents the block to the round core with a valid/ready handshake and holds it until the core accepts it.

Parameters:
- NBYTES, 16, bytes per block; block width = 8*NBYTES.
- CNT_W, 4, byte counter width; must satisfy 2**CNT_W >= NBYTES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- byte_in  input  8  byte from the input multiplexer output
- byte_is_key  input  1  multiplexer select for this byte: 1 = key byte, 0 = plaintext byte
- byte_valid  input  1  byte_in/byte_is_key are valid this cycle
- byte_ready  output  1  loader accepts a byte this cycle
- clear  input  1  synchronous abort: discard any partial or held block
- block_out  output  8*NBYTES  assembled block, big-endian
- block_is_key  output  1  tag latched from the first byte of the block
- block_valid  output  1  block_out/block_is_key are valid and stable
- block_ready  input  1  core accepts the block this cycle
- tag_err  output  1  sticky flag: the tag changed inside a block

Behaviour:
- Reset (rst=1 at clk edge) forces:
  - state=FILL, count=0, block_out=0, block_is_key=0, tag_err=0.
  - block_valid=0; byte_ready=1 from the first cycle after reset.
- Byte accept means byte_valid && byte_ready at the clk edge.
- State FILL:
  - byte_ready=1, block_valid=0.
  - On accept: byte_in is written to block_out[8*(NBYTES-count)-1 -: 8], then count increments.
  - count==0 on accept: block_is_key <= byte_is_key.
  - count!=0 on accept with byte_is_key != block_is_key: tag_err <= 1. The byte is still stored and the block tag is unchanged.
  - Accept while count==NBYTES-1: count <= 0, state <= HOLD.
  - Bytes not yet written in a partial block keep their previous values; no zero-fill.
- State HOLD:
  - byte_ready=0, block_valid=1. block_out and block_is_key are held stable.
  - block_ready=1: state <= FILL. block_valid drops and byte_ready rises in the next cycle.
  - No byte is accepted in the release cycle.
- Latency:
  - block_valid rises on the cycle after the 16th byte is accepted.
  - Minimum 17 cycles per block at full rate: 16 accept cycles plus 1 handoff cycle.
- Back-pressure: block_ready low in HOLD stalls indefinitely. byte_ready stays 0 and the upstream multiplexer source must hold its byte.
- byte_valid low in FILL: no change; count is held (gaps allowed).
- clear:
  - Takes priority over byte accept and block_ready in the same cycle.
  - Next state: count=0, state=FILL, block_valid=0.
  - block_out, block_is_key and tag_err are unchanged.
  - A byte presented with clear is dropped.
- rst has priority over clear.
- tag_err is cleared only by rst.
- byte_ready and block_valid are purely state-decoded, with no combinational path from byte_valid or block_ready.
- Counter range is 0..NBYTES-1 only; values >= NBYTES are unreachable.

Test Plan:
- Full block: after reset, feed bytes 0x00..0x0F with byte_is_key=0 back to back, block_ready=1 -> block_valid high exactly 1 cycle after the 16th accept, block_out=0x000102030405060708090A0B0C0D0E0F, block_is_key=0. Next cycle: block_valid=0, byte_ready=1.
- Key tag and back-pressure: feed 16 bytes 0xFF..0xF0 with byte_is_key=1, block_ready=0 for 10 cycles -> block_valid held, byte_ready=0, block_out=0xFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0 stable, block_is_key=1. Raise block_ready -> release after 1 cycle.
- Gapped input: 16 bytes 0xA5 with byte_valid toggling 1/0 -> block_valid after the 16th accepted byte only, count unaffected by idle cycles, block_out = 0xA5 repeated 16 times.
- Tag error: first byte tag=0, 5th byte tag=1 -> tag_err=1 from the cycle after the 5th accept. block_is_key stays 0. tag_err remains 1 through later blocks until rst.
- Clear mid-block: accept 7 bytes, then clear together with byte_valid=1 -> that byte is dropped and count=0. The next 16 bytes 0x10..0x1F give block_out=0x101112...1F.
- Reset mid-HOLD: rst while block_valid=1 -> next cycle block_valid=0, block_out=0, tag_err=0, byte_ready=1.
